// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial programming port and registered run-mode reads.
// Define LOADER_CHECKSUM_EN to build the running byte checksum; otherwise checksum reads 0.
module instr_mem_loader #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 8,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 En_Program,
    input  logic                                 byte_valid,
    input  logic [BYTE_W-1:0]                    byte_data,
    output logic                                 byte_ready,
    input  logic [ADDR_W+$clog2(WORD_BYTES)-1:0] rd_addr,
    output logic [BYTE_W*WORD_BYTES-1:0]         rd_data,
    output logic                                 load_done,
    output logic [ADDR_W:0]                      word_count,
    output logic                                 overflow,
    output logic [BYTE_W-1:0]                    checksum,
    output logic [2:0]                           dbg_state
);

    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FULL  = 3'd2,
        S_FLUSH = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high;
    // byte_ready is a registered decode of LOAD and never depends combinationally on byte_valid.

    state_t              r_state;
    logic                r_byte_ready;
    logic [LANE_W-1:0]   r_lane;
    logic [WORD_W-1:0]   r_assy;
    logic [ADDR_W:0]     r_word_count;
    logic                r_overflow;
    logic                r_load_done;
    logic [WORD_W-1:0]   r_rd_data;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    state_t              w_next;
    logic                w_accept;
    logic                w_last_lane;
    logic [LANE_W-1:0]   w_lane_sel;
    logic [LANE_W-1:0]   w_lane_nxt;
    logic [WORD_W-1:0]   w_assy_upd;
    logic [WORD_W-1:0]   w_wdata;
    logic                w_commit;
    logic [ADDR_W:0]     w_count_nxt;
    logic                w_enter_load;
    logic [LANE_W-1:0]   w_unused_lo;

    assign w_unused_lo = rd_addr[LANE_W-1:0];

    always_comb begin
        w_accept    = (r_state == S_LOAD) && byte_valid && r_byte_ready;
        w_last_lane = (r_lane == LAST_LANE);
        w_lane_sel  = (BIG_ENDIAN != 0) ? (LAST_LANE - r_lane) : r_lane;
        w_assy_upd  = r_assy;
        w_assy_upd[int'(w_lane_sel)*BYTE_W +: BYTE_W] = byte_data;
        // The assembly register is cleared after every commit, so a flush commits it as-is.
        w_commit    = (w_accept && w_last_lane) || (r_state == S_FLUSH);
        w_wdata     = (r_state == S_FLUSH) ? r_assy : w_assy_upd;
        w_lane_nxt  = r_lane;
        if (r_state == S_FLUSH) begin
            w_lane_nxt = '0;
        end else if (w_accept) begin
            w_lane_nxt = w_last_lane ? '0 : r_lane + LANE_W'(1);
        end
        w_count_nxt = r_word_count + {{ADDR_W{1'b0}}, w_commit};

        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = En_Program ? S_RUN : S_LOAD;
            S_LOAD: begin
                if (En_Program) begin
                    w_next = (w_lane_nxt == '0) ? S_RUN : S_FLUSH;
                end else if (w_count_nxt == FULL_COUNT) begin
                    w_next = S_FULL;
                end
            end
            S_FULL:  w_next = En_Program ? S_RUN : S_FULL;
            S_FLUSH: w_next = S_RUN;
            S_RUN:   w_next = En_Program ? S_RUN : S_LOAD;
            default: w_next = S_IDLE;
        endcase
        w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_lane       <= '0;
            r_assy       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
            r_load_done  <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == S_LOAD);
            r_rd_data    <= (w_next == S_RUN) ? r_mem[rd_addr[ADDR_W+LANE_W-1:LANE_W]] : '0;
            if (w_enter_load) begin
                r_lane       <= '0;
                r_assy       <= '0;
                r_word_count <= '0;
                r_overflow   <= 1'b0;
                r_load_done  <= 1'b0;
            end else begin
                r_lane       <= w_lane_nxt;
                r_word_count <= w_count_nxt;
                if (w_commit) begin
                    r_assy <= '0;
                end else if (w_accept) begin
                    r_assy <= w_assy_upd;
                end
                if (r_state == S_FULL && byte_valid) begin
                    r_overflow <= 1'b1;
                end
                if (w_next == S_RUN && r_state != S_RUN && r_state != S_IDLE) begin
                    r_load_done <= 1'b1;
                end
            end
        end
    end

    // Commits only happen below full, so the low pointer bits always address a fresh word.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_word_count[ADDR_W-1:0]] <= w_wdata;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] r_checksum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_enter_load) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + byte_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign byte_ready = r_byte_ready;
    assign rd_data    = r_rd_data;
    assign load_done  = r_load_done;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule
